// File: rtl/alu_pipe.sv
// alu_pipe: pipelined parametrised ALU with valid/ready handshake and NZVC flag register
module alu_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c
);
  localparam int SHW = $clog2(WIDTH);
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] res_c;
  logic [3:0]       nzvc_c;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] sf_q;
  logic [WIDTH-1:0] res_q [STAGES];
  logic [3:0]       nzvc_q [STAGES];
  // Subtraction reuses the adder as A + ~B + 1, so carry means "no borrow"
  assign is_sub   = cntrl == 3'b011;
  assign is_arith = cntrl[2:1] == 2'b01;
  assign b_op     = is_sub ? ~B : B;
  assign sum      = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  assign sh       = B[SHW-1:0];
  // First-stage operation select and flag generation
  always_comb begin
    res_c = B;
    case (cntrl)
      3'b000: res_c = B;
      3'b001: res_c = A << sh;
      3'b010,
      3'b011: res_c = sum[WIDTH-1:0];
      3'b100: res_c = A & B;
      3'b101: res_c = A | B;
      3'b110: res_c = A ^ B;
      default: res_c = A >> sh;
    endcase
    nzvc_c = {res_c[WIDTH-1],
              res_c == '0,
              is_arith && (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]),
              is_arith && sum[WIDTH]};
  end
  // Global-stall pipeline; payload only loads behind a valid op so bubbles carry no X
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      sf_q  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        res_q[i]  <= '0;
        nzvc_q[i] <= '0;
      end
    end else if (in_ready) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        res_q[0]  <= res_c;
        nzvc_q[0] <= nzvc_c;
        sf_q[0]   <= set_flags;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          res_q[i]  <= res_q[i-1];
          nzvc_q[i] <= nzvc_q[i-1];
          sf_q[i]   <= sf_q[i-1];
        end
      end
    end
  end
  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);
  assign result    = res_q[STAGES-1];
  assign {negative, zero, overflow, carry_out} = nzvc_q[STAGES-1];
  // Architectural flags commit only on an output handshake of a flag-setting op
  always_ff @(posedge clk) begin
    if (reset)
      {flag_n, flag_z, flag_v, flag_c} <= '0;
    else if (out_valid && out_ready && sf_q[STAGES-1])
      {flag_n, flag_z, flag_v, flag_c} <= nzvc_q[STAGES-1];
  end
endmodule
